bsg_manycore_axil_rx_read_slave: RTL

AXI4-Lite read-only slave that drains the manycore-to-host request stream. It sits directly downstream of the rx serializer/buffer stage and consumes its `axil_data_width_p`-wide words and its free-credit count. The host CPU reads it as memory-mapped registers: a data register that pops one word per read, an occupancy/credit register and a status register.

---
 rtl/bsg_manycore_link_to_axil_pkg.sv | 26 ++
 rtl/bsg_manycore_axil_rx_read_slave.sv | 114 +++++++++++
 2 files changed

// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// Shared definitions for the manycore link to AXI-Lite bridge: register
// offsets, AXI response codes and the rx read slave FSM states.
package bsg_manycore_link_to_axil_pkg;

    localparam logic [3:0] rx_data_offset_gp    = 4'h0;
    localparam logic [3:0] rx_credits_offset_gp = 4'h4;
    localparam logic [3:0] rx_status_offset_gp  = 4'h8;
    localparam logic [3:0] rx_peek_offset_gp    = 4'hC;

    typedef enum logic [1:0] {
        e_axil_okay   = 2'b00,
        e_axil_slverr = 2'b10,
        e_axil_decerr = 2'b11
    } axil_resp_e;

    typedef enum logic {
        e_rx_idle = 1'b0,
        e_rx_resp = 1'b1
    } rx_read_state_e;

    // Registers are word aligned; only the word index selects a register.
    function automatic logic [1:0] reg_idx(input logic [3:0] offset);
        return offset[3:2];
    endfunction

endpackage

// File: rtl/bsg_manycore_axil_rx_read_slave.sv
// AXI-Lite read-only slave draining the rx stage: data pop, credits, status.
// Optional BSG_MANYCORE_AXIL_RX_PEEK_EN maps a non-popping head read at 0xC.
module bsg_manycore_axil_rx_read_slave
    import bsg_manycore_link_to_axil_pkg::*;
#(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    parameter int credits_width_p   = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,

    input  logic [axil_addr_width_p-1:0] s_axil_araddr_i,
    input  logic [2:0]                   s_axil_arprot_i,
    input  logic                         s_axil_arvalid_i,
    output logic                         s_axil_arready_o,

    output logic [axil_data_width_p-1:0] s_axil_rdata_o,
    output logic [1:0]                   s_axil_rresp_o,
    output logic                         s_axil_rvalid_o,
    input  logic                         s_axil_rready_i,

    input  logic [axil_data_width_p-1:0] rx_data_i,
    input  logic                         rx_v_i,
    output logic                         rx_yumi_o,
    input  logic [credits_width_p-1:0]   rx_credits_i
);

    rx_read_state_e               state_q, state_d;
    logic [axil_data_width_p-1:0] rdata_q, rdata_d;
    axil_resp_e                   rresp_q, rresp_d;

    logic [axil_data_width_p-1:0] dec_data;
    axil_resp_e                   dec_resp;
    logic                         dec_pop;
    logic                         ar_hs;

    // Base decode, protection and byte offset belong to the parent.
    logic unused_bits;
    assign unused_bits = ^{s_axil_arprot_i,
                           s_axil_araddr_i[axil_addr_width_p-1:4],
                           s_axil_araddr_i[1:0]};

    always_comb begin
        dec_data = '0;
        dec_resp = e_axil_okay;
        dec_pop  = 1'b0;
        case (s_axil_araddr_i[3:2])
            reg_idx(rx_data_offset_gp): begin
                if (rx_v_i) begin
                    dec_data = rx_data_i;
                    dec_pop  = 1'b1;
                end else begin
                    dec_resp = e_axil_slverr;
                end
            end
            reg_idx(rx_credits_offset_gp): begin
                dec_data[credits_width_p-1:0] = rx_credits_i;
            end
            reg_idx(rx_status_offset_gp): begin
                dec_data[0] = rx_v_i;
            end
            default: begin
`ifdef BSG_MANYCORE_AXIL_RX_PEEK_EN
                if (rx_v_i) dec_data = rx_data_i;
                else        dec_resp = e_axil_slverr;
`else
                dec_resp = e_axil_decerr;
`endif
            end
        endcase
    end

    assign s_axil_arready_o = reset_n_i & (state_q == e_rx_idle);
    assign s_axil_rvalid_o  = (state_q == e_rx_resp);
    assign s_axil_rdata_o   = rdata_q;
    assign s_axil_rresp_o   = rresp_q;

    assign ar_hs     = s_axil_arready_o & s_axil_arvalid_i;
    // dec_pop already implies rx_v_i, so the pop never fires on an empty head.
    assign rx_yumi_o = ar_hs & dec_pop;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        case (state_q)
            e_rx_idle: begin
                if (ar_hs) begin
                    rdata_d = dec_data;
                    rresp_d = dec_resp;
                    state_d = e_rx_resp;
                end
            end
            e_rx_resp: begin
                if (s_axil_rready_i) state_d = e_rx_idle;
            end
            default: state_d = e_rx_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= e_rx_idle;
            rdata_q <= '0;
            rresp_q <= e_axil_okay;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

endmodule
